// File: rtl/mm_uart_tx_if.sv
// Processor-side bus into the memory-mapped UART transmitter.
//   addr     : 16-bit bus address
//   mm_re    : external read strobe from DM decode
//   mm_we    : external write strobe from DM decode
//   wrt_data : 16-bit write data
//   rd_data  : 16-bit registered read data returned by the peripheral
interface mm_uart_tx_if;
    logic [15:0] addr;
    logic        mm_re;
    logic        mm_we;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;

    modport master (output addr, output mm_re, output mm_we, output wrt_data, input rd_data);
    modport slave  (input addr, input mm_re, input mm_we, input wrt_data, output rd_data);
endinterface

// File: rtl/mm_uart_tx.sv
// Memory-mapped UART transmitter (8N1) on the external side of the data memory.
// Registers (relative to BASE_ADDR): +0 TXDATA (write pushes a byte, reads 0),
// +1 STATUS {13'b0, ovf, full, tx_busy} (any write clears ovf), +2 BAUD divisor.
//   clk     : system clock, all logic on posedge
//   rst     : synchronous active-high reset
//   bus     : processor bus (addr, mm_re, mm_we, wrt_data, rd_data)
//   TX      : serial output, idle high
//   tx_busy : FIFO non-empty or frame in flight
module mm_uart_tx #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [15:0] BAUD_DEFAULT = 16'd434,
    parameter logic [15:0] BASE_ADDR    = 16'hC000
) (
    input  logic          clk,
    input  logic          rst,
    mm_uart_tx_if.slave   bus,
    output logic          TX,
    output logic          tx_busy
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [15:0] DATA_ADDR = BASE_ADDR;
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] BAUD_ADDR = BASE_ADDR + 16'd2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [15:0]   baud;
    logic [15:0]   rd_data;

    logic [1:0]    state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   div;
    logic [15:0]   baud_cnt;

    logic          mm_sel, hit_data, hit_stat, hit_baud;
    logic          full, push_req, push, pop, bit_end;
    logic [15:0]   rd_next;

    assign mm_sel   = (bus.addr[15:13] != 3'b000);
    assign hit_data = mm_sel && (bus.addr == DATA_ADDR);
    assign hit_stat = mm_sel && (bus.addr == STAT_ADDR);
    assign hit_baud = mm_sel && (bus.addr == BAUD_ADDR);

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
    assign full     = (count == CW'(FIFO_DEPTH));
    assign push_req = bus.mm_we && hit_data;
    assign push     = push_req && !full;
    assign pop      = (state == IDLE) && (count != '0);
    assign bit_end  = (baud_cnt == div - 16'd1);

    assign tx_busy     = (state != IDLE) || (count != '0);
    assign bus.rd_data = rd_data;

    always_comb begin
        rd_next = '0;
        if (hit_stat)
            rd_next = {13'b0, ovf, full, tx_busy};
        else if (hit_baud)
            rd_next = baud;
    end

    always_comb begin
        case (state)
            START:   TX = 1'b0;
            DATA:    TX = shift[0];
            default: TX = 1'b1;
        endcase
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= bus.wrt_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            baud     <= BAUD_DEFAULT;
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            div      <= 16'd1;
            baud_cnt <= '0;
        end else begin
            // A simultaneous read and write performs only the write.
            if (bus.mm_re && !bus.mm_we)
                rd_data <= rd_next;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Setting on an overflowing push takes priority over a clearing write.
            if (push_req && full)
                ovf <= 1'b1;
            else if (bus.mm_we && hit_stat)
                ovf <= 1'b0;

            if (bus.mm_we && hit_baud)
                baud <= bus.wrt_data;

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= fifo[rd_ptr];
                        div      <= (baud == 16'd0) ? 16'd1 : baud;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule
